// File: rtl/store_rmw_unit_if.sv
// Store request / memory bus bundle for store_rmw_unit.
//   master : requester + memory model side (drives req_*, mem_rdata)
//   slave  : the store unit (drives req_ready, mem_*, done, err)
// Signals:
//   req_valid/req_ready  request handshake
//   req_addr/size/data   byte address, log2 size, right-justified data
//   mem_addr             word-aligned address for mem_rd_en / mem_wr_en
//   mem_rdata            read data, valid one cycle after mem_rd_en
//   mem_wdata            merged write word
//   done / err           one-cycle commit / reject pulses
interface store_rmw_unit_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32
);
   logic              req_valid;
   logic              req_ready;
   logic [ADDR_W-1:0] req_addr;
   logic [1:0]        req_size;
   logic [DATA_W-1:0] req_data;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_rd_en;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_wr_en;
   logic [DATA_W-1:0] mem_wdata;
   logic              done;
   logic              err;

   modport master (
      output req_valid, req_addr, req_size, req_data, mem_rdata,
      input  req_ready, mem_addr, mem_rd_en, mem_wr_en, mem_wdata, done, err
   );

   modport slave (
      input  req_valid, req_addr, req_size, req_data, mem_rdata,
      output req_ready, mem_addr, mem_rd_en, mem_wr_en, mem_wdata, done, err
   );
endinterface

// File: rtl/store_rmw_unit.sv
// Sub-word store unit: full-word stores are written directly, partial
// stores read the containing word, merge the new bytes in and write back.
// Misaligned or oversized requests are rejected with an err pulse.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-high reset
//   bus    store_rmw_unit_if.slave (request handshake + memory bus)
//
// state | meaning
// IDLE  | ready for a request
// RD    | read of the containing word issued
// MG    | read data captured
// WR    | merged (or full) word written, done pulsed
// ERR   | request rejected, err pulsed
module store_rmw_unit #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32
) (
   input  logic clk,
   input  logic reset,
   store_rmw_unit_if.slave bus
);
   localparam int B  = DATA_W / 8;
   localparam int LB = $clog2(B);

   typedef enum logic [2:0] {IDLE, RD, MG, WR, ERR} state_t;

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] addr_q;
   logic [1:0]        size_q;
   logic [DATA_W-1:0] data_q;
   logic [DATA_W-1:0] rdata_q;
   logic [ADDR_W-1:0] addr_hold;
   logic [DATA_W-1:0] wdata_hold;
   logic [ADDR_W-1:0] word_addr;
   logic [DATA_W-1:0] merged;
   logic              req_bad;
   logic              req_full;

   always_comb begin : req_decode
      int n;
      int off;
      n        = 1 << bus.req_size;
      off      = int'(bus.req_addr[LB-1:0]);
      req_bad  = (int'(bus.req_size) > LB) || ((off & (n - 1)) != 0);
      req_full = (int'(bus.req_size) == LB);
   end

   assign word_addr = {addr_q[ADDR_W-1:LB], {LB{1'b0}}};

   // Shift the store data up to its lane offset, then take only the lanes
   // the store covers; every other lane keeps the word that was read.
   always_comb begin : merge_word
      logic [DATA_W-1:0] shifted;
      int n;
      int off;
      n       = 1 << size_q;
      off     = int'(addr_q[LB-1:0]);
      shifted = data_q << (8 * off);
      merged  = rdata_q;
      for (int i = 0; i < B; i++) begin
         if (i >= off && i < off + n) merged[8*i +: 8] = shifted[8*i +: 8];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt     = state;
      bus.req_ready = 1'b0;
      bus.mem_rd_en = 1'b0;
      bus.mem_wr_en = 1'b0;
      bus.done      = 1'b0;
      bus.err       = 1'b0;
      bus.mem_addr  = addr_hold;
      bus.mem_wdata = wdata_hold;
      case (state)
         IDLE: begin
            bus.req_ready = 1'b1;
            if (bus.req_valid) begin
               if (req_bad)       state_nxt = ERR;
               else if (req_full) state_nxt = WR;
               else               state_nxt = RD;
            end
         end
         RD: begin
            bus.mem_rd_en = 1'b1;
            bus.mem_addr  = word_addr;
            state_nxt     = MG;
         end
         MG: state_nxt = WR;
         WR: begin
            bus.mem_wr_en = 1'b1;
            bus.done      = 1'b1;
            bus.mem_addr  = word_addr;
            bus.mem_wdata = (int'(size_q) == LB) ? data_q : merged;
            state_nxt     = IDLE;
         end
         ERR: begin
            bus.err   = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // mem_addr / mem_wdata hold their last driven value outside RD and WR.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         addr_q     <= '0;
         size_q     <= '0;
         data_q     <= '0;
         rdata_q    <= '0;
         addr_hold  <= '0;
         wdata_hold <= '0;
      end else begin
         if (state == IDLE && bus.req_valid) begin
            addr_q <= bus.req_addr;
            size_q <= bus.req_size;
            data_q <= bus.req_data;
         end
         if (state == MG)                 rdata_q    <= bus.mem_rdata;
         if (state == RD || state == WR)  addr_hold  <= bus.mem_addr;
         if (state == WR)                 wdata_hold <= bus.mem_wdata;
      end
   end
endmodule

// File: doc/store_rmw_unit.md
STORE_RMW_UNIT -- requirements
Module: store_rmw_unit

Interface
REQ-001 Parameter DATA_W, default 32, memory word width in bits; legal values 32 or 64.
REQ-002 Parameter ADDR_W, default 32, byte-address width in bits.
REQ-003 Port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1, asynchronous active-high reset.
REQ-005 Port req_valid, input, 1, store request present.
REQ-006 Port req_ready, output, 1, unit can accept a request.
REQ-007 Port req_addr, input, ADDR_W, byte address of the store.
REQ-008 Port req_size, input, 2, store size: 0 = byte, 1 = half, 2 = word, 3 = dword.
REQ-009 Port req_data, input, DATA_W, store data, right-justified (low bits significant).
REQ-010 Port mem_addr, output, ADDR_W, word-aligned memory address (low log2(DATA_W/8) bits zero).
REQ-011 Port mem_rd_en, output, 1, memory read strobe.
REQ-012 Port mem_rdata, input, DATA_W, read data, valid exactly one cycle after mem_rd_en.
REQ-013 Port mem_wr_en, output, 1, memory write strobe.
REQ-014 Port mem_wdata, output, DATA_W, merged write word.
REQ-015 Port done, output, 1, one-cycle pulse when a store is committed.
REQ-016 Port err, output, 1, one-cycle pulse when a request is rejected.

Function
REQ-017 Define B = DATA_W/8 and off = req_addr[log2(B)-1:0]; N = 2^req_size bytes.
REQ-018 FSM states IDLE, RD, MG, WR, ERR.
REQ-019 req_ready is 1 only in IDLE; a request is accepted on a cycle with req_valid && req_ready.
REQ-020 On accept, the unit latches addr, size and data; the inputs may change afterwards.
REQ-021 A request is an error if N > B, or if off is not a multiple of N. Error requests go IDLE->ERR->IDLE, with err=1 in ERR and no memory strobes.
REQ-022 A legal request with N == B (full word) goes IDLE->WR->IDLE, with no read issued.
REQ-023 A legal request with N < B goes IDLE->RD->MG->WR->IDLE.
REQ-024 RD: mem_rd_en=1 and mem_addr = latched word address.
REQ-025 MG: mem_rdata is captured into an internal register; no strobes are asserted.
REQ-026 Merge: byte lanes off..off+N-1 of the captured word are replaced by bytes 0..N-1 of the latched data; all other lanes keep the captured value.
REQ-027 WR: mem_wr_en=1, mem_addr = word address, mem_wdata = merged word (or latched data for a full word), and done=1.
REQ-028 Latency from the accept edge to mem_wr_en: 1 cycle for a full word, 3 cycles for a partial store. Throughput: one store per 2 cycles (full) or 4 cycles (partial).
REQ-029 mem_rd_en and mem_wr_en are never high in the same cycle; done and err are never high in the same cycle.
REQ-030 Outside RD and WR, mem_rd_en=0 and mem_wr_en=0; mem_addr and mem_wdata hold their last values.
REQ-031 req_valid held high while the unit is busy is ignored until it returns to IDLE; no request is dropped or duplicated.
REQ-032 Byte lane 0 is the least-significant byte (little-endian lane numbering).

Reset
REQ-033 While reset=1 the FSM is in IDLE and the captured and latched registers are cleared; mem_rd_en, mem_wr_en, done, err, mem_addr and mem_wdata are all 0, and req_ready=1.
REQ-034 Reset asserted mid-operation (RD, MG or WR) aborts the store immediately; no write strobe occurs after reset rises.
REQ-035 After reset deasserts, the first accept can occur on the first rising clock edge.

Verification
REQ-036 DATA_W=32, sb: addr 0x1002, data 0xAB, mem_rdata 0x11223344 -> mem_rd_en at 0x1000, then 2 cycles later mem_wr_en with wdata 0x11AB3344, addr 0x1000, done=1.
REQ-037 DATA_W=32, sh: addr 0x2002, data 0xBEEF, rdata 0xCAFE0000 -> wdata 0xBEEF0000, write 3 cycles after accept.
REQ-038 DATA_W=32, sw: addr 0x3000, data 0xDEADBEEF -> no mem_rd_en; mem_wr_en 1 cycle after accept with wdata 0xDEADBEEF.
REQ-039 DATA_W=32: sh at addr 0x4001 -> err pulse, no strobes. sd (size 3) at any address -> err pulse, no strobes.
REQ-040 DATA_W=64, sb: addr 0x0007, data 0x5A, rdata 0x0102030405060708 -> wdata 0x5A02030405060708 at addr 0x0000.
REQ-041 Reset asserted during MG of an sb -> no mem_wr_en, no done; all outputs 0 and req_ready=1; the next request completes normally.
